// File: rtl/pulse_counter_pkg.sv
// Shared types and helpers for the pulse counter framer.
// Holds the FSM state encoding, default sync header and frame length math.
package pulse_counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    localparam logic [7:0] HEADER_DEF = 8'hA5;

    function automatic int frame_len(
        input int n_ch,
        input int cnt_w,
        input int ts_w
    );
        return 9 + n_ch + n_ch * cnt_w + ts_w;
    endfunction

endpackage

// File: rtl/pulse_sync_counter.sv
// Synchroniser, rising-edge detector and saturating counter for one input.
// A clear that coincides with an edge leaves the counter at 1.
module pulse_sync_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_async,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt,
    output logic         o_max
);

    logic         r_s1;
    logic         r_s2;
    logic         r_s3;
    logic [W-1:0] r_cnt;
    logic         w_edge;

    assign w_edge = r_s2 & ~r_s3;
    assign o_max  = &r_cnt;
    assign o_cnt  = r_cnt;

    // two-flop synchroniser plus history flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // saturating count; clear keeps a coincident edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= {{(W-1){1'b0}}, w_edge};
        end else if (w_edge && !o_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_counter_framer.sv
// N-channel pulse counter with window timer and serial frame readout.
// Optional: define FRAME_PARITY_EN to append an even-parity bit.
module pulse_counter_framer
    import pulse_counter_pkg::*;
#(
    parameter int          N_CH         = 4,
    parameter int          CNT_W        = 12,
    parameter int          TS_W         = 12,
    parameter int          WINDOW_TICKS = 3600,
    parameter logic [7:0]  HEADER       = HEADER_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] ch_in,
    input  logic            rtc_tick,
    output logic            serial_out,
    output logic            serial_valid,
    output logic            frame_start,
    output logic            busy,
    output logic [N_CH-1:0] ovf_ch,
    output logic            ovf_any
);

    localparam int L = frame_len(N_CH, CNT_W, TS_W);
`ifdef FRAME_PARITY_EN
    localparam int FL = L + 1;
`else
    localparam int FL = L;
`endif
    localparam int              BC_W = $clog2(FL + 1);
    localparam logic [BC_W-1:0] LAST = BC_W'(FL - 1);
    localparam logic [TS_W-1:0] WIN  = TS_W'(WINDOW_TICKS);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] w_cnt [N_CH];
    logic [N_CH-1:0]  w_max;
    logic [TS_W-1:0]  w_tick;
    logic             w_tick_max;
    logic             w_clr;
    logic             w_win;
    logic             w_trig;
    logic             r_pend;
    logic             r_pend_win;
    logic             r_cause;
    logic [FL-1:0]    r_shift;
    logic [BC_W-1:0]  r_bit;
    logic [L-1:0]     w_frame;

    assign w_clr  = (r_state == LOAD);
    assign w_win  = (w_tick >= WIN) | w_tick_max;
    assign w_trig = w_win | (|w_max);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pulse_sync_counter #(.W(CNT_W)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .i_async (ch_in[g]),
            .i_clr   (w_clr),
            .o_cnt   (w_cnt[g]),
            .o_max   (w_max[g])
        );
    end

    pulse_sync_counter #(.W(TS_W)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .i_async (rtc_tick),
        .i_clr   (w_clr),
        .o_cnt   (w_tick),
        .o_max   (w_tick_max)
    );

    // assemble the frame from live state, MSB first
    always_comb begin
        w_frame = '0;
        w_frame[L-1 -: 8] = HEADER;
        w_frame[L-9] = r_cause;
        w_frame[L-10 -: N_CH] = w_max;
        for (int i = 0; i < N_CH; i++) begin
            w_frame[TS_W + (N_CH-1-i)*CNT_W +: CNT_W] = w_cnt[i];
        end
        w_frame[TS_W-1:0] = w_tick;
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next state and serial outputs
    always_comb begin
        w_next       = r_state;
        serial_valid = 1'b0;
        frame_start  = 1'b0;
        serial_out   = 1'b0;
        busy         = (r_state != IDLE);
        ovf_ch       = w_max;
        ovf_any      = |w_max;
        unique case (r_state)
            IDLE: begin
                if (w_trig || r_pend) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_next = SHIFT;
            end
            SHIFT: begin
                serial_valid = 1'b1;
                serial_out   = r_shift[FL-1];
                frame_start  = (r_bit == '0);
                if (r_bit == LAST) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // cause, pending trigger, snapshot and shifter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend     <= 1'b0;
            r_pend_win <= 1'b0;
            r_cause    <= 1'b0;
            r_shift    <= '0;
            r_bit      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_trig || r_pend) begin
                        r_cause    <= w_win | (r_pend & r_pend_win);
                        r_pend     <= 1'b0;
                        r_pend_win <= 1'b0;
                    end
                end
                LOAD: begin
`ifdef FRAME_PARITY_EN
                    r_shift <= {w_frame, ^w_frame};
`else
                    r_shift <= w_frame;
`endif
                    r_bit   <= '0;
                end
                SHIFT: begin
                    r_shift <= {r_shift[FL-2:0], 1'b0};
                    r_bit   <= r_bit + 1'b1;
                    if (w_trig) begin
                        r_pend     <= 1'b1;
                        r_pend_win <= r_pend_win | w_win;
                    end
                end
                default: begin
                    r_pend <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_counter_framer.sv
// Scoreboard bench for pulse_counter_framer with WINDOW_TICKS=4.
// Stimulus pushes expected frames; a negedge monitor collects and compares.
module tb_pulse_counter_framer;

    localparam int N_CH  = 4;
    localparam int CNT_W = 12;
    localparam int TS_W  = 12;
    localparam int L     = 9 + N_CH + N_CH * CNT_W + TS_W;
`ifdef FRAME_PARITY_EN
    localparam int FL = L + 1;
`else
    localparam int FL = L;
`endif

    typedef struct {
        logic [FL-1:0] bits;
        int            len;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [N_CH-1:0] ch_in;
    logic            rtc_tick;
    logic            serial_out;
    logic            serial_valid;
    logic            frame_start;
    logic            busy;
    logic [N_CH-1:0] ovf_ch;
    logic            ovf_any;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    logic [FL-1:0] rx;
    int            rx_n = 0;
    int            frames_done = 0;
    int            idle_run = 0;
    int            last_idle = -1;
    bit            fs_bad = 0;
    bit            prev_busy = 0;
    logic [127:0]  got;
    logic [127:0]  want;

    pulse_counter_framer #(
        .N_CH         (N_CH),
        .CNT_W        (CNT_W),
        .TS_W         (TS_W),
        .WINDOW_TICKS (4),
        .HEADER       (8'hA5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ch_in        (ch_in),
        .rtc_tick     (rtc_tick),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .busy         (busy),
        .ovf_ch       (ovf_ch),
        .ovf_any      (ovf_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic logic [FL-1:0] mk(
        input logic c, input logic [3:0] ovf,
        input logic [11:0] c0, input logic [11:0] c1,
        input logic [11:0] c2, input logic [11:0] c3,
        input logic [11:0] ts);
        logic [L-1:0] f;
        f = {8'hA5, c, ovf, c0, c1, c2, c3, ts};
`ifdef FRAME_PARITY_EN
        return {f, ^f};
`else
        return f;
`endif
    endfunction

    task automatic push(input logic [FL-1:0] b, input int len);
        exp_t e;
        e.bits = b;
        e.len  = len;
        q.push_back(e);
    endtask

    // monitor: collect frame bits, compare on frame end
    always @(negedge clk) begin : mon
        exp_t e;
        if (serial_valid) begin
            if ((rx_n == 0) != frame_start) fs_bad = 1'b1;
            rx = {rx[FL-2:0], serial_out};
            rx_n++;
        end else if (rx_n > 0) begin
            if (q.size() == 0) begin
                chk("frame_unexpected", 128'(rx_n), 128'd0);
            end else begin
                e = q.pop_front();
                chk("frame_len", 128'(rx_n), 128'(e.len));
                got  = '0;
                want = '0;
                for (int i = 0; i < e.len; i++) begin
                    got[i]  = rx[i];
                    want[i] = e.bits[FL - e.len + i];
                end
                chk("frame_bits", got, want);
                chk("frame_start", 128'(fs_bad), 128'd0);
            end
            rx_n   = 0;
            fs_bad = 1'b0;
            frames_done++;
        end
        if (!busy) begin
            idle_run++;
        end else begin
            if (!prev_busy) last_idle = idle_run;
            idle_run = 0;
        end
        prev_busy = busy;
    end

    task automatic pulse(input int ch);
        @(negedge clk);
        ch_in[ch] = 1'b1;
        repeat (2) @(negedge clk);
        ch_in[ch] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        rtc_tick = 1'b1;
        repeat (2) @(negedge clk);
        rtc_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("frame_wait", 128'(frames_done >= target), 128'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        reset    = 1'b1;
        ch_in    = '0;
        rtc_tick = 1'b0;
        @(negedge clk);
        ch_in[0] = 1'b1;
        @(negedge clk);
        ch_in[0] = 1'b0;
        @(negedge clk);
        chk("reset_outs", 128'({serial_out, serial_valid, frame_start,
                                busy, ovf_ch, ovf_any}), 128'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_after_reset", 128'({busy, serial_valid, ovf_any}), 128'd0);

        // window frame; reset-time toggle must not be counted
        for (int i = 0; i < 3; i++) pulse(0);
        for (int i = 0; i < 5; i++) pulse(1);
        ticks(3);
        push(mk(1'b1, 4'b0000, 12'd3, 12'd5, 12'd0, 12'd0, 12'd4), FL);
        tick();
        wait_frames(1, 300);
        chk("busy_after_frame", 128'(busy), 128'd0);

        // saturation of channel 0
        for (int i = 0; i < 4094; i++) pulse(0);
        push(mk(1'b0, 4'b0001, 12'hFFF, 12'd0, 12'd0, 12'd0, 12'd0), FL);
        @(negedge clk);
        ch_in[0] = 1'b1;
        for (int i = 0; i < 8 && !ovf_any; i++) @(negedge clk);
        chk("ovf_ch_sat", 128'(ovf_ch), 128'd1);
        ch_in[0] = 1'b0;
        wait_frames(2, 300);
        chk("ovf_cleared", 128'({ovf_any, ovf_ch}), 128'd0);

        // channel 2 edge lands in the LOAD cycle
        ticks(3);
        push(mk(1'b1, 4'b0000, 12'd0, 12'd0, 12'd0, 12'd0, 12'd4), FL);
        @(negedge clk);
        rtc_tick = 1'b1;
        repeat (2) @(negedge clk);
        rtc_tick = 1'b0;
        ch_in[2] = 1'b1;
        repeat (2) @(negedge clk);
        ch_in[2] = 1'b0;
        repeat (2) @(negedge clk);
        wait_frames(3, 300);
        ticks(3);
        push(mk(1'b1, 4'b0000, 12'd0, 12'd0, 12'd1, 12'd0, 12'd4), FL);
        tick();
        wait_frames(4, 300);

        // window completes while a frame is shifting
        pulse(3);
        pulse(3);
        ticks(3);
        push(mk(1'b1, 4'b0000, 12'd0, 12'd0, 12'd0, 12'd2, 12'd4), FL);
        tick();
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        chk("busy_rise", 128'(busy), 128'd1);
        push(mk(1'b1, 4'b0000, 12'd0, 12'd0, 12'd0, 12'd0, 12'd4), FL);
        ticks(4);
        wait_frames(6, 400);
        chk("idle_gap", 128'(last_idle), 128'd1);

        // reset while bit 20 is on the line
        pulse(1);
        ticks(3);
        push(mk(1'b1, 4'b0000, 12'd0, 12'd1, 12'd0, 12'd0, 12'd4), 21);
        tick();
        for (int i = 0; i < 200 && rx_n != 21; i++) begin
            @(negedge clk);
            #1;
        end
        chk("reach_bit20", 128'(rx_n), 128'd21);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("valid_after_reset", 128'({serial_valid, busy}), 128'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("no_bits_after_reset", 128'(frames_done), 128'd7);
        push(mk(1'b1, 4'b0000, 12'd0, 12'd0, 12'd0, 12'd0, 12'd4), FL);
        ticks(4);
        wait_frames(8, 300);

        repeat (5) @(negedge clk);
        chk("queue_empty", 128'(q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
